// File: rtl/param_ctrl_pkg.sv
// Shared constants, button FSM state type and saturating step helpers for
// the push-button parameter controller.
package param_ctrl_pkg;

  // Value ranges shared with the display driver and the DDS core.
  localparam logic [15:0] FREQ_MIN   = 16'd1;
  localparam logic [15:0] FREQ_MAX   = 16'd20000;
  localparam logic [15:0] FREQ_DEF   = 16'd1000;
  localparam logic [15:0] FSTEP_FINE = 16'd10;
  localparam logic [15:0] FSTEP_CRS  = 16'd1000;
  localparam logic [7:0]  AMP_MAX    = 8'd99;
  localparam logic [7:0]  AMP_DEF    = 8'd50;
  localparam logic [7:0]  ASTEP_FINE = 8'd1;
  localparam logic [7:0]  ASTEP_CRS  = 8'd10;

  // Button slots in the conditioned-event vector.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_MODE = 2;
  localparam int NUM_BTN  = 3;

  typedef enum logic [1:0] {
    BTN_IDLE      = 2'd0,
    BTN_PRESSED   = 2'd1,
    BTN_REPEATING = 2'd2
  } btn_state_e;

  // One saturating frequency step; the signed 17-bit sum can never wrap.
  function automatic logic [15:0] freq_apply(input logic [15:0] cur,
                                             input logic coarse,
                                             input logic dn);
    logic signed [16:0] step;
    logic signed [16:0] acc;
    step = coarse ? $signed({1'b0, FSTEP_CRS}) : $signed({1'b0, FSTEP_FINE});
    acc  = dn ? ($signed({1'b0, cur}) - step) : ($signed({1'b0, cur}) + step);
    if (acc > $signed({1'b0, FREQ_MAX})) begin
      acc = $signed({1'b0, FREQ_MAX});
    end else if (acc < $signed({1'b0, FREQ_MIN})) begin
      acc = $signed({1'b0, FREQ_MIN});
    end
    return acc[15:0];
  endfunction

  // One saturating amplitude step, clamped to 0..AMP_MAX.
  function automatic logic [7:0] amp_apply(input logic [7:0] cur,
                                           input logic coarse,
                                           input logic dn);
    logic signed [8:0] step;
    logic signed [8:0] acc;
    step = coarse ? $signed({1'b0, ASTEP_CRS}) : $signed({1'b0, ASTEP_FINE});
    acc  = dn ? ($signed({1'b0, cur}) - step) : ($signed({1'b0, cur}) + step);
    if (acc > $signed({1'b0, AMP_MAX})) begin
      acc = $signed({1'b0, AMP_MAX});
    end else if (acc < 9'sd0) begin
      acc = 9'sd0;
    end
    return acc[7:0];
  endfunction

endpackage

// File: rtl/param_ctrl_btn_cond.sv
// Conditions one raw push-button: 2-FF synchroniser, debounce, press edge
// and optional hold-to-repeat, producing single-cycle event pulses.
module param_ctrl_btn_cond
  import param_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_RATE   = 10_000_000,
  parameter bit REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic evt
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int HMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST  = HW'(REP_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST = HW'(REP_RATE - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          evt_q, evt_d;

  // Debounce: accept a new level only after an unbroken run of mismatches.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  // Press / repeat FSM; the event is registered so it trails the level edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    evt_d      = 1'b0;
    case (state_q)
      BTN_IDLE: begin
        hold_cnt_d = '0;
        if (deb_q) begin
          evt_d   = 1'b1;
          state_d = BTN_PRESSED;
        end
      end
      BTN_PRESSED: begin
        if (!deb_q) begin
          state_d    = BTN_IDLE;
          hold_cnt_d = '0;
        end else if (REP_EN) begin
          if (hold_cnt_q == DLY_LAST) begin
            evt_d      = 1'b1;
            hold_cnt_d = '0;
            state_d    = BTN_REPEATING;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      BTN_REPEATING: begin
        if (!deb_q) begin
          state_d    = BTN_IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == RATE_LAST) begin
          evt_d      = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d    = BTN_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State registers; everything clears so a held button re-debounces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= BTN_IDLE;
      hold_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/param_ctrl.sv
// Turns up/down/mode push-buttons into registered freq (Hz) and amp (%)
// words with saturating steps; mode selects which field is edited.
module param_ctrl
  import param_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_RATE   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_mode,
  input  logic        sw_coarse,
  output logic [15:0] freq,
  output logic [7:0]  amp,
  output logic        edit_sel,
  output logic        updated
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_evt;
  logic [15:0]        freq_q, freq_d;
  logic [7:0]         amp_q, amp_d;
  logic               edit_sel_q, edit_sel_d;
  logic               updated_q, updated_d;
  logic               do_step;

  assign btn_raw = {btn_mode, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      param_ctrl_btn_cond #(
        .DEB_CYCLES (DEB_CYCLES),
        .REP_DELAY  (REP_DELAY),
        .REP_RATE   (REP_RATE),
        .REP_EN     (gi != BTN_MODE)
      ) u_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw[gi]),
        .evt     (btn_evt[gi])
      );
    end
  endgenerate

  // Apply at most one step to the field selected before any mode toggle.
  always_comb begin
    freq_d     = freq_q;
    amp_d      = amp_q;
    edit_sel_d = edit_sel_q ^ btn_evt[BTN_MODE];
    do_step    = btn_evt[BTN_UP] ^ btn_evt[BTN_DOWN];
    if (do_step) begin
      if (!edit_sel_q) begin
        freq_d = freq_apply(freq_q, sw_coarse, btn_evt[BTN_DOWN]);
      end else begin
        amp_d = amp_apply(amp_q, sw_coarse, btn_evt[BTN_DOWN]);
      end
    end
    updated_d = (freq_d != freq_q) || (amp_d != amp_q);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q     <= FREQ_DEF;
      amp_q      <= AMP_DEF;
      edit_sel_q <= 1'b0;
      updated_q  <= 1'b0;
    end else begin
      freq_q     <= freq_d;
      amp_q      <= amp_d;
      edit_sel_q <= edit_sel_d;
      updated_q  <= updated_d;
    end
  end

  assign freq     = freq_q;
  assign amp      = amp_q;
  assign edit_sel = edit_sel_q;
  assign updated  = updated_q;

endmodule

// File: tb/tb_param_ctrl.sv
// Bench for param_ctrl: table of button transactions, hand-written timing
// and reset sequences, then random button activity, all compared each
// cycle against a behavioural model of the button and step rules.
module tb_param_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int HN  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0, sw_coarse = 1'b0;
  logic [15:0] freq;
  logic [7:0]  amp;
  logic        edit_sel, updated;

  always #5 clk = ~clk;

  param_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_mode(btn_mode), .sw_coarse(sw_coarse), .freq(freq), .amp(amp),
    .edit_sel(edit_sel), .updated(updated)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_freq, m_amp;
  bit m_edit, m_upd;
  bit lvl [3];
  int rise [3];
  bit evt_prev [3];
  bit hist [3][HN];
  int cyc = 16;

  typedef struct {
    logic [2:0] mask;      // bit0 up, bit1 down, bit2 mode
    logic       coarse;
    int         hold;
    int         exp_freq;
    int         exp_amp;
    logic       exp_edit;
    int         exp_upds;
  } vec_t;

  vec_t vecs [21];

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_freq = 1000; m_amp = 50; m_edit = 1'b0; m_upd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 1'b0; rise[i] = 0; evt_prev[i] = 1'b0;
      for (int k = 0; k < HN; k++) hist[i][k] = 1'b0;
    end
  endtask

  // One clock edge of the model: apply last edge's events, derive this
  // edge's events from hold time, then re-evaluate the debounced levels.
  task automatic model_step();
    bit r [3];
    bit evt_now [3];
    int nf, na, st, h;
    bit all_diff;
    r[0] = btn_up; r[1] = btn_down; r[2] = btn_mode;
    nf = m_freq; na = m_amp;
    if (evt_prev[0] != evt_prev[1]) begin
      if (!m_edit) begin
        st = sw_coarse ? 1000 : 10;
        nf = clamp(evt_prev[0] ? m_freq + st : m_freq - st, 1, 20000);
      end else begin
        st = sw_coarse ? 10 : 1;
        na = clamp(evt_prev[0] ? m_amp + st : m_amp - st, 0, 99);
      end
    end
    m_upd  = (nf != m_freq) || (na != m_amp);
    m_freq = nf; m_amp = na;
    if (evt_prev[2]) m_edit = !m_edit;
    for (int i = 0; i < 3; i++) begin
      evt_now[i] = 1'b0;
      if (lvl[i]) begin
        h = cyc - rise[i] - 1;
        if (h == 0) evt_now[i] = 1'b1;
        else if (i != 2 && h >= RD && ((h - RD) % RR) == 0) evt_now[i] = 1'b1;
      end
      hist[i][cyc & (HN - 1)] = r[i];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[i][(cyc - 2 - j) & (HN - 1)] == lvl[i]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[i] = !lvl[i];
        if (lvl[i]) rise[i] = cyc;
      end
      evt_prev[i] = evt_now[i];
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check_val("freq", int'(freq), m_freq);
    check_val("amp", int'(amp), m_amp);
    check_val("edit_sel", int'(edit_sel), int'(m_edit));
    check_val("updated", int'(updated), int'(m_upd));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else begin
      for (int i = 0; i < 3; i++) hist[i][cyc & (HN - 1)] = 1'b0;
      cyc++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous assert (checked without a clock edge), release after cycles.
  task automatic reset_async(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_freq", int'(freq), 1000);
    check_val("rst_async_amp", int'(amp), 50);
    check_val("rst_async_edit", int'(edit_sel), 0);
    check_val("rst_async_upd", int'(updated), 0);
    model_reset();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int upd_t [$];
    int e0, cnt;
    logic [8:0] bounce;
    bit bst [3];
    int rem [3];

    vecs[0]  = '{3'b001, 1'b0, 10,  1010,  50, 1'b0, 1};
    vecs[1]  = '{3'b010, 1'b1, 10,  10,    50, 1'b0, 1};
    vecs[2]  = '{3'b010, 1'b1, 10,  1,     50, 1'b0, 1};
    vecs[3]  = '{3'b010, 1'b0, 10,  1,     50, 1'b0, 0};
    vecs[4]  = '{3'b001, 1'b1, 140, 20000, 50, 1'b0, 20};
    vecs[5]  = '{3'b010, 1'b0, 10,  19990, 50, 1'b0, 1};
    vecs[6]  = '{3'b001, 1'b1, 10,  20000, 50, 1'b0, 1};
    vecs[7]  = '{3'b001, 1'b1, 10,  20000, 50, 1'b0, 0};
    vecs[8]  = '{3'b011, 1'b0, 10,  20000, 50, 1'b0, 0};
    vecs[9]  = '{3'b010, 1'b1, 10,  19000, 50, 1'b0, 1};
    vecs[10] = '{3'b101, 1'b0, 10,  19010, 50, 1'b1, 1};
    vecs[11] = '{3'b010, 1'b1, 10,  19010, 40, 1'b1, 1};
    vecs[12] = '{3'b010, 1'b1, 10,  19010, 30, 1'b1, 1};
    vecs[13] = '{3'b010, 1'b1, 10,  19010, 20, 1'b1, 1};
    vecs[14] = '{3'b010, 1'b1, 10,  19010, 10, 1'b1, 1};
    vecs[15] = '{3'b010, 1'b0, 38,  19010, 5,  1'b1, 5};
    vecs[16] = '{3'b010, 1'b1, 10,  19010, 0,  1'b1, 1};
    vecs[17] = '{3'b010, 1'b1, 10,  19010, 0,  1'b1, 0};
    vecs[18] = '{3'b011, 1'b1, 10,  19010, 0,  1'b1, 0};
    vecs[19] = '{3'b001, 1'b1, 10,  19010, 10, 1'b1, 1};
    vecs[20] = '{3'b100, 1'b0, 10,  19010, 10, 1'b0, 0};

    // Power-on reset
    model_reset();
    repeat (3) tick();
    check_val("por_freq", int'(freq), 1000);
    check_val("por_amp", int'(amp), 50);
    check_val("por_edit", int'(edit_sel), 0);
    check_val("por_upd", int'(updated), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Bouncy press then a 30-cycle hold: one press step plus two repeats
    bounce = 9'b100110011;
    for (int i = 8; i >= 0; i--) begin
      btn_up = bounce[i];
      tick();
      if (updated) upd_t.push_back(cyc - 1);
    end
    btn_up = 1'b0;
    repeat (2) begin
      tick();
      if (updated) upd_t.push_back(cyc - 1);
    end
    btn_up = 1'b1;
    e0 = cyc;
    repeat (30) begin
      tick();
      if (updated) upd_t.push_back(cyc - 1);
    end
    btn_up = 1'b0;
    repeat (12) begin
      tick();
      if (updated) upd_t.push_back(cyc - 1);
    end
    check_val("bounce_upd_count", upd_t.size(), 3);
    check_val("bounce_freq", int'(freq), 1030);
    if (upd_t.size() == 3) begin
      check_val("press_latency", upd_t[0] - e0, 7);
      check_val("first_repeat_gap", upd_t[1] - upd_t[0], RD);
      check_val("repeat_rate_gap", upd_t[2] - upd_t[1], RR);
    end
    $display("bounce+hold: freq=%0d updates=%0d", freq, upd_t.size());

    // Reset in the middle of a hold; the held button counts as a new press
    btn_up = 1'b1;
    repeat (30) tick();
    reset_async(2);
    repeat (10) tick();
    btn_up = 1'b0;
    repeat (15) tick();
    check_val("held_through_reset_freq", int'(freq), 1010);
    $display("held through reset: freq=%0d", freq);
    reset_async(2);
    repeat (3) tick();

    // Table of button transactions from the reset state
    for (int k = 0; k < 21; k++) begin
      sw_coarse = vecs[k].coarse;
      {btn_mode, btn_down, btn_up} = vecs[k].mask;
      cnt = 0;
      repeat (vecs[k].hold) begin
        tick();
        if (updated) cnt++;
      end
      {btn_mode, btn_down, btn_up} = 3'b000;
      repeat (15) begin
        tick();
        if (updated) cnt++;
      end
      check_val($sformatf("vec%0d_freq", k), int'(freq), vecs[k].exp_freq);
      check_val($sformatf("vec%0d_amp", k), int'(amp), vecs[k].exp_amp);
      check_val($sformatf("vec%0d_edit", k), int'(edit_sel), int'(vecs[k].exp_edit));
      check_val($sformatf("vec%0d_updates", k), cnt, vecs[k].exp_upds);
      $display("vec%0d mask=%b coarse=%0d hold=%0d -> freq=%0d amp=%0d edit=%0d updates=%0d",
               k, vecs[k].mask, vecs[k].coarse, vecs[k].hold, freq, amp, edit_sel, cnt);
    end

    // Random button activity with bounces and long holds
    for (int i = 0; i < 3; i++) begin
      bst[i] = 1'b0;
      rem[i] = $urandom_range(1, 20);
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          bst[i] = !bst[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
        end
        rem[i]--;
      end
      btn_up = bst[0]; btn_down = bst[1]; btn_mode = bst[2];
      if ($urandom_range(0, 63) == 0) sw_coarse = !sw_coarse;
      tick();
    end
    {btn_mode, btn_down, btn_up} = 3'b000;
    repeat (20) tick();
    $display("random phase done: freq=%0d amp=%0d edit=%0d", freq, amp, edit_sel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
